// File: rtl/uart2wifi_pkg.sv
// Shared types and constants for the WiFi bring-up sequencer: FSM states,
// ASCII codes and the AT command ROM.
package uart2wifi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_OK,
    ST_DONE,
    ST_ERROR
  } at_state_t;

  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int unsigned ROM_DEPTH_C = 32;
  localparam int unsigned NUM_CMDS_C  = 2;

  // "AT\r\n" then "AT+CWMODE=1\r\n"; each command ends in LF, unused tail is zero.
  localparam logic [7:0] CMD_ROM [ROM_DEPTH_C] = '{
    8'h41, 8'h54, ASCII_CR, ASCII_LF,
    8'h41, 8'h54, 8'h2B, 8'h43, 8'h57, 8'h4D, 8'h4F, 8'h44, 8'h45, 8'h3D, 8'h31,
    ASCII_CR, ASCII_LF,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/at_cmd_sequencer_debouncer.sv
// Switch conditioning: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on the debounced 0->1 transition.
module switch_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= switch_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/at_cmd_sequencer.sv
// Streams the AT command ROM into the UART TX and waits for "OK" on the RX
// stream after each command; reports DONE on board_led0, timeouts on error.
module at_cmd_sequencer
  import uart2wifi_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000,
  parameter int unsigned NUM_CMDS        = NUM_CMDS_C,
  parameter int unsigned ROM_DEPTH       = ROM_DEPTH_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       error,
  output logic       board_led0
);

  localparam int unsigned PTR_W = $clog2(ROM_DEPTH);
  localparam int unsigned CMD_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam logic [CMD_W-1:0] LAST_CMD = CMD_W'(NUM_CMDS - 1);

  at_state_t         state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              match_q, match_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              press;
  logic              ok;
  logic [7:0]        rom_byte;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i   (clk),
    .rst_i   (rst),
    .switch_i(switch_in),
    .press_o (press)
  );

  assign rom_byte = CMD_ROM[ptr_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    ok      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (press) begin
          state_d = ST_SEND;
          ptr_d   = '0;
          cmd_d   = '0;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          ptr_d = ptr_q + 1'b1;
          if (rom_byte == ASCII_LF) begin
            state_d = ST_WAIT_OK;
            match_d = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      ST_WAIT_OK: begin
        ok = rx_valid && (rx_data == ASCII_K) && match_q;
        if (rx_valid) begin
          match_d = (rx_data == ASCII_O);
        end
        // OK on the expiry cycle still counts as success.
        if (ok) begin
          cmd_d   = cmd_q + 1'b1;
          state_d = (cmd_q == LAST_CMD) ? ST_DONE : ST_SEND;
        end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cmd_q   <= '0;
      match_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode the state register only, so reset clears them at once.
  assign tx_valid   = (state_q == ST_SEND);
  assign tx_data    = tx_valid ? rom_byte : 8'h00;
  assign busy       = (state_q == ST_SEND) || (state_q == ST_WAIT_OK);
  assign error      = (state_q == ST_ERROR);
  assign board_led0 = (state_q == ST_DONE);

endmodule

// File: doc/at_cmd_sequencer.md
Name: at_cmd_sequencer

Overview:
- Controller that sequences the UART datapath of uart2wifi_core_ip to bring up the WiFi module.
- A debounced rising edge on switch_in starts the sequence. The block streams a fixed list of AT command strings, byte by byte, into the UART transmitter. After each command it waits for an "OK" reply on the UART receive byte stream.
- board_led0 reports completion; a timeout aborts the sequence into an error state.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: cycles switch_in must be stable before the debounced level changes.
- TIMEOUT_CYCLES, 32'd50_000_000: maximum cycles in WAIT_OK before error (1 s at 50 MHz).
- NUM_CMDS, 2: number of commands in the package ROM.
- ROM_DEPTH, 32: total bytes in the package ROM.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- switch_in  in  1  raw board switch; asynchronous to clk.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts a byte when tx_valid and tx_ready are both high.
- rx_data  in  8  byte from UART RX.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle.
- busy  out  1  high in SEND and WAIT_OK.
- error  out  1  high in ERROR.
- board_led0  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, all state): state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, error=0, board_led0=0, byte pointer=0, command index=0, match flag=0, timeout counter=0, synchroniser and debounced level=0.
- Input conditioning:
  - switch_in passes through a 2-flop synchroniser.
  - The debounced level takes the synchronised value after it differs for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - press = single-cycle pulse on the 0->1 transition of the debounced level.
- States: IDLE, SEND, WAIT_OK, DONE, ERROR.
- IDLE / DONE / ERROR:
  - On press, go to SEND with byte pointer=0, command index=0, error=0, board_led0=0.
  - tx_valid=1 and tx_data=ROM[0] are registered the cycle after the press pulse.
- SEND:
  - tx_data=ROM[ptr] and tx_valid=1 are held stable until a handshake completes.
  - On handshake: ptr++. If the byte sent was 8'h0A (LF, command terminator), drop tx_valid, clear the match flag and timeout counter, and go to WAIT_OK. Otherwise present the next byte on the following cycle; back-to-back bytes are allowed.
- WAIT_OK:
  - tx_valid=0; the timeout counter increments every cycle.
  - On rx_valid: byte 'O' (8'h4F) sets the match flag. Byte 'K' (8'h4B) with the match flag set means OK received. Any other byte clears the match flag.
  - OK received: command index++. If it was the last command (index==NUM_CMDS-1), go to DONE; otherwise go to SEND with ptr already at the next command's first byte.
  - When the counter reaches TIMEOUT_CYCLES-1 without OK, go to ERROR. If OK arrives in the same cycle the timeout expires, OK wins.
- rx_valid outside WAIT_OK is ignored; the match flag is not updated.
- press while busy (SEND or WAIT_OK) is ignored.
- tx_ready held low indefinitely in SEND: the block stalls with no timeout (TX backpressure is legal).
- The pointer never wraps: the ROM terminator structure guarantees ptr<ROM_DEPTH at the last LF.
- rst asserted mid-transfer: tx_valid drops immediately (asynchronously) and the block returns to IDLE with no partial-state retention.

Decomposition:
- Package uart2wifi_pkg holds:
  - the state enum type (at_state_t);
  - ASCII constants ASCII_O, ASCII_K, ASCII_LF, ASCII_CR;
  - the localparam byte-array CMD_ROM = "AT\r\n" followed by "AT+CWMODE=1\r\n" (17 bytes used, rest 8'h00).
- One sub-module: switch_debouncer (synchroniser, stability counter, press pulse output), parameterised by DEBOUNCE_CYCLES.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, tx_ready tied 1.
  - Press switch, reply "OK\r\n" after each LF -> tx emits 41 54 0D 0A, then 17 bytes total in order; board_led0=1 and busy=0 after the second K.
  - Bounce switch 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one sequence starts; no tx_valid during the bounce.
- TX backpressure: tx_ready toggled 1-of-3 cycles -> tx_data stable while tx_valid=1 and ready=0; byte order is unchanged; no byte is duplicated or dropped.
- OK matching: after the first LF, send 'O','X','K' then 'O','O','K' -> the first triple is not accepted; the second completes command 0 and SEND resumes with 8'h41.
- Timeout: no RX after the first LF -> error=1 exactly 100 cycles after WAIT_OK entry; a second press clears error and restarts from 8'h41. Also drive 'K' on the expiry cycle after 'O' -> OK wins, no error.
- Reset: assert rst mid-SEND (after 2 bytes) -> tx_valid=0 asynchronously and all outputs return to reset values. A press after deassertion restarts from byte 0.
